// File: rtl/led_scheduler.sv
// Shares a 10-LED bank between game-over blink, hit flash and lives display
// by fixed priority (OVER > FLASH > SCORE); outputs are registered.
module led_scheduler #(
   parameter int unsigned HALF_PERIOD = 12500000,
   parameter int unsigned FLASH_LEN   = 25000000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       over,
   input  logic       hit,
   input  logic [3:0] lives,
   output logic [9:0] ledr,
   output logic [1:0] mode
);

   typedef enum logic [1:0] {
      SCORE = 2'b00,
      FLASH = 2'b01,
      OVER  = 2'b10
   } state_t;

   localparam logic [31:0] FLASH_LAST    = 32'(FLASH_LEN - 1);
   localparam logic [31:0] OVER_LAST     = 32'(2 * HALF_PERIOD - 1);
   localparam logic [31:0] HALF          = 32'(HALF_PERIOD);
   localparam logic [9:0]  FLASH_PATTERN = 10'b1010101010;
   localparam logic [9:0]  ALL_ON        = 10'h3FF;

   state_t      state;
   logic [31:0] cnt;

   // Lives 10..15 saturate to a full bar because every bit compares true.
   function automatic logic [9:0] thermo(input logic [3:0] n);
      logic [9:0] t;
      for (int i = 0; i < 10; i++) t[i] = (n > 4'(i));
      return t;
   endfunction

   // The state register is itself the registered mode output.
   assign mode = state;

   // NOTE: all state lives in one clocked block with non-blocking assignments,
   // so ledr is computed from the next cnt rather than read back from cnt.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= SCORE;
         cnt   <= '0;
         ledr  <= '0;
      end else if (over) begin
         state <= OVER;
         if (state != OVER || cnt == OVER_LAST) begin
            cnt  <= '0;
            ledr <= '0;
         end else begin
            cnt  <= cnt + 32'd1;
            ledr <= (cnt + 32'd1 >= HALF) ? ALL_ON : '0;
         end
      end else begin
         case (state)
            OVER: begin
               state <= SCORE;
               cnt   <= '0;
               ledr  <= thermo(lives);
            end
            FLASH: begin
               if (hit) begin
                  cnt  <= '0;
                  ledr <= FLASH_PATTERN;
               end else if (cnt == FLASH_LAST) begin
                  state <= SCORE;
                  cnt   <= '0;
                  ledr  <= thermo(lives);
               end else begin
                  cnt  <= cnt + 32'd1;
                  ledr <= FLASH_PATTERN;
               end
            end
            default: begin
               cnt <= '0;
               if (hit) begin
                  state <= FLASH;
                  ledr  <= FLASH_PATTERN;
               end else begin
                  state <= SCORE;
                  ledr  <= thermo(lives);
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_led_scheduler.sv
// Bench for led_scheduler: an edge-indexed behavioural model checked every
// cycle, plus directed scenarios with hand-computed literal expectations.
module tb_led_scheduler;

   localparam int HP = 4;
   localparam int FL = 6;

   logic       clk;
   logic       rst_n;
   logic       over;
   logic       hit;
   logic [3:0] lives;
   logic [9:0] ledr;
   logic [1:0] mode;

   int n_checks = 0;
   int n_fail   = 0;

   led_scheduler #(.HALF_PERIOD(HP), .FLASH_LEN(FL)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .over  (over),
      .hit   (hit),
      .lives (lives),
      .ledr  (ledr),
      .mode  (mode)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [9:0] bar(input int l);
      int n;
      n = (l > 10) ? 10 : l;
      return 10'((1 << n) - 1);
   endfunction

   // Model: edges are numbered k; a flash covers edges [hit_edge, hit_edge+FL),
   // and the blink phase is the edge distance from entering game-over.
   int         k           = 0;
   int         over_start  = 0;
   int         flash_until = 0;
   bit         m_over      = 1'b0;
   logic [9:0] e_ledr;
   logic [1:0] e_mode;

   always begin
      @(posedge clk);
      k++;
      if (!rst_n) begin
         m_over      = 1'b0;
         flash_until = 0;
         e_ledr      = '0;
         e_mode      = 2'b00;
      end else if (over) begin
         if (!m_over) over_start = k;
         m_over      = 1'b1;
         flash_until = 0;
         e_mode      = 2'b10;
         e_ledr      = (((k - over_start) % (2 * HP)) >= HP) ? 10'h3FF : 10'h000;
      end else begin
         if (m_over) begin
            m_over      = 1'b0;
            flash_until = 0;
         end else if (hit) begin
            flash_until = k + FL;
         end
         if (k < flash_until) begin
            e_mode = 2'b01;
            e_ledr = 10'b1010101010;
         end else begin
            e_mode = 2'b00;
            e_ledr = bar(int'(lives));
         end
      end
      #1;
      check("model_ledr", 12'(ledr), 12'(e_ledr));
      check("model_mode", 12'(mode), 12'(e_mode));
   end

   task automatic edges(input int n);
      repeat (n) @(negedge clk);
   endtask

   localparam int NL = 5;
   logic [3:0] lv_in  [NL] = '{4'd0, 4'd1, 4'd9, 4'd10, 4'd15};
   logic [9:0] lv_exp [NL] = '{10'h000, 10'h001, 10'h1FF, 10'h3FF, 10'h3FF};

   initial begin
      rst_n = 1'b0;
      over  = 1'b0;
      hit   = 1'b0;
      lives = 4'd3;
      edges(2);
      check("reset_ledr", 12'(ledr), 12'h000);
      check("reset_mode", 12'(mode), 12'h000);

      // First edge after release shows the lives bar.
      rst_n = 1'b1;
      edges(1);
      check("first_edge_ledr", 12'(ledr), 12'h007);
      check("first_edge_mode", 12'(mode), 12'h000);
      lives = 4'd12;
      edges(1);
      check("lives12_sat", 12'(ledr), 12'h3FF);

      for (int i = 0; i < NL; i++) begin
         lives = lv_in[i];
         edges(1);
         check("lives_table", 12'(ledr), 12'(lv_exp[i]));
      end

      // Single hit: six flash edges, then back to the bar.
      lives = 4'd5;
      hit   = 1'b1;
      edges(1);
      hit = 1'b0;
      check("flash_start_ledr", 12'(ledr), 12'h2AA);
      check("flash_start_mode", 12'(mode), 12'h001);
      edges(5);
      check("flash_last_mode", 12'(mode), 12'h001);
      edges(1);
      check("flash_end_ledr", 12'(ledr), 12'h01F);
      check("flash_end_mode", 12'(mode), 12'h000);

      // Re-hit on the 4th flash edge: 9 flash edges total; lives change ignored mid-flash.
      hit = 1'b1;
      edges(1);
      hit   = 1'b0;
      lives = 4'd2;
      edges(2);
      check("lives_frozen_flash", 12'(ledr), 12'h2AA);
      hit = 1'b1;
      edges(1);
      hit = 1'b0;
      edges(5);
      check("reflash_last_mode", 12'(mode), 12'h001);
      edges(1);
      check("reflash_end_ledr", 12'(ledr), 12'h003);
      check("reflash_end_mode", 12'(mode), 12'h000);

      // Game over held for 20 edges with hit pulses sprinkled in.
      over = 1'b1;
      for (int j = 0; j < 20; j++) begin
         hit = (j % 5 == 2);
         edges(1);
         if (j == 0) check("over_j0", 12'(ledr), 12'h000);
         if (j == 3) check("over_j3", 12'(ledr), 12'h000);
         if (j == 4) check("over_j4", 12'(ledr), 12'h3FF);
         if (j == 7) check("over_j7", 12'(ledr), 12'h3FF);
         if (j == 8) check("over_j8", 12'(ledr), 12'h000);
         if (j == 12) check("over_mode", 12'(mode), 12'h002);
      end
      hit  = 1'b0;
      over = 1'b0;
      edges(1);
      check("over_exit_ledr", 12'(ledr), 12'h003);
      check("over_exit_mode", 12'(mode), 12'h000);

      // over and hit together: over wins, no flash afterwards.
      over = 1'b1;
      hit  = 1'b1;
      edges(1);
      check("over_hit_mode", 12'(mode), 12'h002);
      check("over_hit_ledr", 12'(ledr), 12'h000);
      over = 1'b0;
      hit  = 1'b0;
      edges(1);
      check("no_queued_flash", 12'(mode), 12'h000);
      edges(1);
      check("no_queued_flash2", 12'(mode), 12'h000);

      // Asynchronous reset while the blink bar is lit.
      over = 1'b1;
      edges(5);
      check("pre_reset_on", 12'(ledr), 12'h3FF);
      #2 rst_n = 1'b0;
      #1;
      check("async_rst_ledr", 12'(ledr), 12'h000);
      check("async_rst_mode", 12'(mode), 12'h000);
      edges(1);
      rst_n = 1'b1;
      edges(1);
      check("rst_release_over", 12'(mode), 12'h002);
      over = 1'b0;
      edges(1);

      // Reset abandons a flash in progress.
      hit = 1'b1;
      edges(1);
      hit = 1'b0;
      edges(1);
      rst_n = 1'b0;
      #1;
      check("flash_rst_mode", 12'(mode), 12'h000);
      edges(1);
      rst_n = 1'b1;
      edges(1);
      check("flash_rst_after", 12'(ledr), 12'h003);
      check("flash_rst_after_mode", 12'(mode), 12'h000);
      edges(2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/led_scheduler.md
LED_SCHEDULER -- requirements
Module: led_scheduler

Interface
REQ-001 Parameter HALF_PERIOD, default 12500000, game-over blink half-period in clk cycles; legal range >= 1.
REQ-002 Parameter FLASH_LEN, default 25000000, hit-flash duration in clk cycles; legal range >= 1.
REQ-003 The clock port SHALL be: clk  input  1  system clock; all state updates on its rising edge.
REQ-004 The reset port SHALL be: rst_n  input  1  asynchronous reset, active-low.
REQ-005 Port: over  input  1  game-over level; high = game over.
REQ-006 Port: hit  input  1  single-cycle pulse; player was hit.
REQ-007 Port: lives  input  4  remaining-lives count, unsigned.
REQ-008 Port: ledr  output  10  registered LED bank drive.
REQ-009 Port: mode  output  2  registered current state: 00 SCORE, 01 FLASH, 10 OVER; 11 never driven.

Function
REQ-010 The block SHALL share the 10-LED bank among three requesters by fixed priority, highest first: OVER, FLASH, SCORE.
REQ-011 State machine states: SCORE, FLASH, OVER; one 32-bit cycle counter cnt shared by FLASH and OVER.
REQ-012 On each rising clk edge, state, cnt, mode and ledr SHALL update together; ledr and mode SHALL reflect the new state and new cnt (no extra pipeline stage).
REQ-013 SCORE: ledr = thermometer code, bits [n-1:0] set where n = min(lives, 10); lives 0 gives all zero; lives 10-15 saturate to all ones.
REQ-014 SCORE -> FLASH when hit = 1 and over = 0; cnt cleared to 0.
REQ-015 FLASH: ledr = 10'b1010101010 throughout; cnt increments by 1 each cycle.
REQ-016 FLASH -> SCORE on the cycle cnt = FLASH_LEN-1 with hit = 0; FLASH occupies exactly FLASH_LEN cycles.
REQ-017 hit = 1 while in FLASH SHALL restart the flash: cnt reset to 0, state stays FLASH.
REQ-018 Any state -> OVER when over = 1; cnt cleared to 0 on entry; OVER takes precedence over a simultaneous hit.
REQ-019 OVER: cnt counts 0 .. 2*HALF_PERIOD-1 then wraps to 0 with no extra cycle; ledr = all zero for cnt < HALF_PERIOD and all ones otherwise; period exactly 2*HALF_PERIOD cycles.
REQ-020 OVER: hit SHALL be ignored; no flash is queued.
REQ-021 OVER -> SCORE on the first edge with over = 0; cnt cleared; ledr shows the lives thermometer that same edge.
REQ-022 lives changes SHALL appear on ledr on the next edge while in SCORE and SHALL have no effect in FLASH or OVER.
REQ-023 cnt arithmetic is unsigned 32-bit; the comparisons against FLASH_LEN-1 and 2*HALF_PERIOD-1 SHALL be done at 32-bit width, with no overflow at the default values.

Reset
REQ-024 rst_n = 0 SHALL immediately, independent of clk, force state = SCORE, cnt = 0, ledr = 10'b0000000000, mode = 2'b00.
REQ-025 After rst_n rises, the first clk edge SHALL evaluate normally (e.g. ledr shows the lives thermometer, or OVER is entered if over = 1).
REQ-026 Reset asserted mid-FLASH or mid-OVER SHALL abandon the operation; no state survives reset.

Verification (HALF_PERIOD = 4, FLASH_LEN = 6)
REQ-027 Reset release, lives = 3, over = 0, hit = 0 -> after the first edge ledr = 0000000111 and mode = 00; with lives = 12, ledr = 1111111111.
REQ-028 One-cycle hit pulse in SCORE -> mode = 01 and ledr = 1010101010 for exactly 6 edges, then lives thermometer with mode = 00.
REQ-029 Hit repeated 3 cycles into a flash -> flash extends to 6 cycles after the second hit (9 flash cycles total).
REQ-030 over = 1 held for 20 cycles -> ledr sequence 0,0,0,0,all ones x4, repeating, from the entry edge; mode = 10; hit pulses during this time cause no change.
REQ-031 over and hit both asserted on the same edge in SCORE -> OVER entered and ledr = 0; over dropped -> SCORE next edge with no flash.
REQ-032 rst_n asserted asynchronously mid-OVER while ledr = all ones -> ledr = 0 and mode = 00 before the next clk edge.
